// File: rtl/mips_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: CPU vs. loader/DMA.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is CPU priority with a starvation limit.
module mips_mem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [3:0] RL = 4'(READ_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic          lat_we;
  logic [3:0]    wait_cnt;
  logic          grant_dma;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
  // last_dma resets to 1 so the CPU takes the first tie
  logic last_dma;
  assign grant_dma = dma_req & (~cpu_req | ~last_dma);
`else
  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  assign grant_dma = dma_req & (~cpu_req | (starve_cnt == SL));
`endif

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_dma) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  // mem_addr/mem_wdata double as the request latch; they stay put until the next grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      lat_we    <= 1'b0;
      wait_cnt  <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_dma  <= 1'b1;
`else
      starve_cnt <= '0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_req || dma_req) begin
            owner     <= grant_dma;
            lat_we    <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            busy      <= 1'b1;
            state     <= S_ISSUE;
`ifdef MEM_ARB_RR_EN
            last_dma  <= grant_dma;
`else
            if (!grant_dma && dma_req)
              starve_cnt <= (starve_cnt == SL) ? SL : starve_cnt + 4'd1;
            else
              starve_cnt <= '0;
`endif
          end
        end
        S_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (lat_we) begin
            if (owner) dma_ack <= 1'b1;
            else       cpu_ack <= 1'b1;
            state <= S_RESP;
          end else begin
            wait_cnt <= RL;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // count==1 is the cycle the RAM presents the word
          if (wait_cnt == 4'd1) begin
            if (owner) begin
              dma_rdata <= mem_rdata;
              dma_ack   <= 1'b1;
            end else begin
              cpu_rdata <= mem_rdata;
              cpu_ack   <= 1'b1;
            end
            wait_cnt <= '0;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
